// File: rtl/parking_lot_ctrl_multi.sv
// Multi-lane parking lot controller: one entry/exit sequencing FSM per lane
// feeding a shared, saturating occupancy counter with sticky over/underflow flags.
module parking_lot_ctrl_multi #(
  parameter int unsigned LANES = 2,
  parameter int unsigned CAP   = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] in_sig,
  input  logic [LANES-1:0] out_sig,
  input  logic             clr_err,
  output logic [LANES-1:0] entering,
  output logic [LANES-1:0] exiting,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf,
  output logic [LANES-1:0] fault
);

  // Sum width leaves headroom so count + E - X never wraps.
  localparam int unsigned SumW = CNT_W + 4;
  localparam logic signed [SumW-1:0] CapS = SumW'(CAP);

  typedef enum logic [2:0] {
    StIdle,
    StEn1,
    StEn2,
    StEn3,
    StEx1,
    StEx2,
    StEx3,
    StFault
  } lane_state_e;

  lane_state_e state_q [LANES];
  lane_state_e state_d [LANES];

  logic [LANES-1:0] enter_done;
  logic [LANES-1:0] exit_done;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [3:0]       e_cnt, x_cnt;
  logic signed [SumW-1:0] sum;

  // Per-lane transition table; ab = {outer beam A, inner beam B}.
  // Stepping back to the previous state's pattern models a car reversing.
  function automatic lane_state_e lane_next(lane_state_e st, logic [1:0] ab);
    lane_state_e nx;
    nx = st;
    unique case (st)
      StIdle: begin
        case (ab)
          2'b10:   nx = StEn1;
          2'b01:   nx = StEx1;
          2'b11:   nx = StFault;
          default: nx = StIdle;
        endcase
      end
      StEn1: begin
        case (ab)
          2'b10:   nx = StEn1;
          2'b11:   nx = StEn2;
          2'b00:   nx = StIdle;
          default: nx = StFault;
        endcase
      end
      StEn2: begin
        case (ab)
          2'b11:   nx = StEn2;
          2'b01:   nx = StEn3;
          2'b10:   nx = StEn1;
          default: nx = StIdle;
        endcase
      end
      StEn3: begin
        case (ab)
          2'b01:   nx = StEn3;
          2'b00:   nx = StIdle;
          2'b11:   nx = StEn2;
          default: nx = StFault;
        endcase
      end
      StEx1: begin
        case (ab)
          2'b01:   nx = StEx1;
          2'b11:   nx = StEx2;
          2'b00:   nx = StIdle;
          default: nx = StFault;
        endcase
      end
      StEx2: begin
        case (ab)
          2'b11:   nx = StEx2;
          2'b10:   nx = StEx3;
          2'b01:   nx = StEx1;
          default: nx = StIdle;
        endcase
      end
      StEx3: begin
        case (ab)
          2'b10:   nx = StEx3;
          2'b00:   nx = StIdle;
          2'b11:   nx = StEx2;
          default: nx = StFault;
        endcase
      end
      StFault: begin
        nx = (ab == 2'b00) ? StIdle : StFault;
      end
      default: nx = StIdle;
    endcase
    return nx;
  endfunction

  // Next state per lane and completion detection for the shared counter.
  always_comb begin
    enter_done = '0;
    exit_done  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      state_d[i]    = lane_next(state_q[i], {in_sig[i], out_sig[i]});
      enter_done[i] = (state_q[i] == StEn3) && ({in_sig[i], out_sig[i]} == 2'b00);
      exit_done[i]  = (state_q[i] == StEx3) && ({in_sig[i], out_sig[i]} == 2'b00);
    end
  end

  // Net entries against exits, then clamp to [0, CAP] and raise sticky flags.
  always_comb begin
    e_cnt = '0;
    x_cnt = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      e_cnt = e_cnt + 4'(enter_done[i]);
      x_cnt = x_cnt + 4'(exit_done[i]);
    end
    sum     = $signed(SumW'(count_q)) + $signed(SumW'(e_cnt)) - $signed(SumW'(x_cnt));
    count_d = sum[CNT_W-1:0];
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;
    if (sum > CapS) begin
      count_d = CNT_W'(CAP);
      ovf_d   = 1'b1;
    end else if (sum[SumW-1]) begin
      count_d = '0;
      unf_d   = 1'b1;
    end
  end

  // Lane state, pulse, counter and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(LANES); i++) begin
        state_q[i] <= StIdle;
      end
      entering <= '0;
      exiting  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        state_q[i] <= state_d[i];
      end
      entering <= enter_done;
      exiting  <= exit_done;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Status decodes of registered state.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      fault[i] = (state_q[i] == StFault);
    end
  end

  assign count = count_q;
  assign full  = (count_q == CNT_W'(CAP));
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_parking_lot_ctrl_multi.sv
// Directed bench for parking_lot_ctrl_multi with LANES=2, CAP=16, CNT_W=8.
module tb_parking_lot_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_sig, out_sig;
  logic       clr_err;
  logic [1:0] entering, exiting, fault;
  logic [7:0] count;
  logic       full, empty, ovf, unf;

  int n_cmp = 0;
  int n_err = 0;

  parking_lot_ctrl_multi #(.LANES(2), .CAP(16), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_sig   (in_sig),
    .out_sig  (out_sig),
    .clr_err  (clr_err),
    .entering (entering),
    .exiting  (exiting),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .unf      (unf),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  // Apply {A,B} for lane0 (p0) and lane1 (p1), clock once, settle 1 time unit.
  task automatic drive(input logic [1:0] p0, input logic [1:0] p1);
    in_sig  = {p1[1], p0[1]};
    out_sig = {p1[0], p0[0]};
    @(posedge clk);
    #1;
  endtask

  task automatic entry0();
    drive(2'b10, 2'b00);
    drive(2'b11, 2'b00);
    drive(2'b01, 2'b00);
    drive(2'b00, 2'b00);
  endtask

  task automatic test_reset();
    rst = 1'b0; clr_err = 1'b0; in_sig = '0; out_sig = '0;
    #12;
    n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if ({empty, full, ovf, unf} !== 4'b1000) begin
      n_err++; $display("FAIL rst_flags got %b want 1000", {empty, full, ovf, unf}); end
    n_cmp++; if ({entering, exiting, fault} !== 6'b0) begin
      n_err++; $display("FAIL rst_lanes got %b want 0", {entering, exiting, fault}); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_entry();
    logic [1:0] pats [4];
    pats = '{2'b00, 2'b10, 2'b11, 2'b01};
    foreach (pats[k]) begin
      drive(pats[k], 2'b00);
      n_cmp++; if (entering !== 2'b00 || empty !== 1'b1) begin
        n_err++; $display("FAIL entry_pre%0d got ent=%b empty=%b want 00/1", k, entering, empty); end
    end
    drive(2'b00, 2'b00);
    n_cmp++; if (entering !== 2'b01 || count !== 8'd1 || empty !== 1'b0) begin
      n_err++; $display("FAIL entry_done got ent=%b cnt=%0d empty=%b want 01/1/0",
                        entering, count, empty); end
    drive(2'b00, 2'b00);
    n_cmp++; if (entering !== 2'b00 || count !== 8'd1) begin
      n_err++; $display("FAIL entry_pulse_len got ent=%b cnt=%0d want 00/1", entering, count); end
  endtask

  task automatic test_exit();
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b01);
    drive(2'b00, 2'b11);
    drive(2'b00, 2'b10);
    n_cmp++; if (exiting !== 2'b00 || count !== 8'd1) begin
      n_err++; $display("FAIL exit_pre got ex=%b cnt=%0d want 00/1", exiting, count); end
    drive(2'b00, 2'b00);
    n_cmp++; if (exiting !== 2'b10 || count !== 8'd0 || empty !== 1'b1 || unf !== 1'b0) begin
      n_err++; $display("FAIL exit_done got ex=%b cnt=%0d empty=%b unf=%b want 10/0/1/0",
                        exiting, count, empty, unf); end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 5; k++) entry0();
    n_cmp++; if (count !== 8'd5) begin n_err++; $display("FAIL sim_pre got %0d want 5", count); end
    drive(2'b10, 2'b01);
    drive(2'b11, 2'b11);
    drive(2'b01, 2'b10);
    drive(2'b00, 2'b00);
    n_cmp++; if (entering !== 2'b01 || exiting !== 2'b10 || count !== 8'd5 || ovf || unf) begin
      n_err++; $display("FAIL sim_done got ent=%b ex=%b cnt=%0d ovf=%b unf=%b want 01/10/5/0/0",
                        entering, exiting, count, ovf, unf); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 11; k++) entry0();
    n_cmp++; if (count !== 8'd16 || full !== 1'b1 || ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_at_cap got cnt=%0d full=%b ovf=%b want 16/1/0", count, full, ovf); end
    entry0();
    n_cmp++; if (count !== 8'd16 || ovf !== 1'b1 || entering !== 2'b01) begin
      n_err++; $display("FAIL ovf_set got cnt=%0d ovf=%b ent=%b want 16/1/01", count, ovf, entering); end
    clr_err = 1'b1;
    drive(2'b00, 2'b00);
    clr_err = 1'b0;
    n_cmp++; if (ovf !== 1'b0 || count !== 8'd16 || full !== 1'b1) begin
      n_err++; $display("FAIL ovf_clr got ovf=%b cnt=%0d full=%b want 0/16/1", ovf, count, full); end
    // clear and new overflow on the same edge: overflow wins
    drive(2'b10, 2'b00);
    drive(2'b11, 2'b00);
    drive(2'b01, 2'b00);
    clr_err = 1'b1;
    drive(2'b00, 2'b00);
    clr_err = 1'b0;
    n_cmp++; if (ovf !== 1'b1 || count !== 8'd16) begin
      n_err++; $display("FAIL ovf_clr_race got ovf=%b cnt=%0d want 1/16", ovf, count); end
    drive(2'b00, 2'b00);
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    clr_err = 1'b1;
    drive(2'b00, 2'b00);
    clr_err = 1'b0;
  endtask

  task automatic test_fault();
    drive(2'b10, 2'b00);
    n_cmp++; if (fault !== 2'b00) begin n_err++; $display("FAIL fault_en1 got %b want 00", fault); end
    drive(2'b01, 2'b00);
    n_cmp++; if (fault !== 2'b01 || entering !== 2'b00) begin
      n_err++; $display("FAIL fault_set got f=%b ent=%b want 01/00", fault, entering); end
    drive(2'b11, 2'b00);
    n_cmp++; if (fault !== 2'b01) begin n_err++; $display("FAIL fault_hold got %b want 01", fault); end
    drive(2'b00, 2'b00);
    n_cmp++; if (fault !== 2'b00 || entering !== 2'b00 || count !== 8'd16) begin
      n_err++; $display("FAIL fault_exit got f=%b ent=%b cnt=%0d want 00/00/16",
                        fault, entering, count); end
  endtask

  task automatic test_reset_mid();
    drive(2'b10, 2'b00);
    drive(2'b11, 2'b00);
    rst = 1'b0;
    #2;
    n_cmp++; if (count !== 8'd0 || {entering, exiting, fault, ovf, unf, full} !== 9'b0 || !empty) begin
      n_err++; $display("FAIL rstmid got cnt=%0d outs=%b empty=%b want 0/0/1",
                        count, {entering, exiting, fault, ovf, unf, full}, empty); end
    in_sig = 2'b00; out_sig = 2'b01;
    @(posedge clk); #1;
    rst = 1'b1;
    drive(2'b01, 2'b00);
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    n_cmp++; if (entering !== 2'b00 || exiting !== 2'b00 || count !== 8'd0) begin
      n_err++; $display("FAIL rstmid_nopulse got ent=%b ex=%b cnt=%0d want 00/00/0",
                        entering, exiting, count); end
  endtask

  task automatic test_underflow();
    drive(2'b00, 2'b01);
    drive(2'b00, 2'b11);
    drive(2'b00, 2'b10);
    drive(2'b00, 2'b00);
    n_cmp++; if (exiting !== 2'b10 || count !== 8'd0 || unf !== 1'b1 || empty !== 1'b1) begin
      n_err++; $display("FAIL unf_set got ex=%b cnt=%0d unf=%b empty=%b want 10/0/1/1",
                        exiting, count, unf, empty); end
    clr_err = 1'b1;
    drive(2'b00, 2'b00);
    clr_err = 1'b0;
    n_cmp++; if (unf !== 1'b0) begin n_err++; $display("FAIL unf_clr got %b want 0", unf); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] pats [9];
    pats = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01};
    foreach (pats[k]) begin
      drive(pats[k], 2'b00);
      n_cmp++; if (entering !== 2'b00 || fault !== 2'b00) begin
        n_err++; $display("FAIL rev_step%0d got ent=%b f=%b want 00/00", k, entering, fault); end
    end
    drive(2'b00, 2'b00);
    n_cmp++; if (entering !== 2'b01 || count !== 8'd1) begin
      n_err++; $display("FAIL rev_done got ent=%b cnt=%0d want 01/1", entering, count); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_simultaneous();
    test_overflow();
    test_fault();
    test_reset_mid();
    test_underflow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
